// File: rtl/song_sequencer.sv
// Run-time loadable note sequencer advanced by a per-beat tick.
// Presents current/next pitch, hold length and remaining beats.
module song_sequencer #(
   parameter int NOTE_BITS = 4,
   parameter int LEN_BITS  = 4,
   parameter int ADDR_BITS = 6,
   parameter int LANES     = 12,
   parameter int REST_CODE = 15
) (
   input  logic                          game_clock,
   input  logic                          reset,
   input  logic                          wr_en,
   input  logic [ADDR_BITS-1:0]          wr_addr,
   input  logic [NOTE_BITS+LEN_BITS-1:0] wr_data,
   input  logic [ADDR_BITS:0]            song_len,
   input  logic                          start,
   input  logic                          loop_en,
   input  logic                          beat_tick,
   output logic [LANES-1:0]              curr_note,
   output logic [LANES-1:0]              next_note,
   output logic [LEN_BITS-1:0]           hold_length,
   output logic [LEN_BITS-1:0]           beats_left,
   output logic                          note_start,
   output logic                          busy,
   output logic                          done
);

   localparam int DEPTH = 2**ADDR_BITS;
   localparam int WORD  = NOTE_BITS + LEN_BITS;

   typedef enum logic {IDLE, PLAY} state_t;

   state_t                state_q, state_d;
   logic [WORD-1:0]       mem [DEPTH];
   logic [ADDR_BITS-1:0]  idx_q, idx_d;
   logic [ADDR_BITS:0]    len_q, len_d;
   logic [ADDR_BITS:0]    idx_inc;
   logic [ADDR_BITS:0]    song_len_c;
   logic [LEN_BITS-1:0]   beats_q, beats_d;
   logic [LEN_BITS-1:0]   hold_q, hold_d;
   logic [LANES-1:0]      curr_q, curr_d;
   logic                  ns_q, ns_d;
   logic                  done_q, done_d;
   logic                  load, clear;
   logic [WORD-1:0]       load_word;

   // Rests and out-of-range pitches light no lane.
   function automatic logic [LANES-1:0] decode(input logic [WORD-1:0] w);
      logic [NOTE_BITS-1:0] n;
      n = w[WORD-1 -: NOTE_BITS];
      decode = '0;
      if (32'(n) < LANES && 32'(n) != REST_CODE)
         decode = LANES'(1) << n;
   endfunction

   // A zero-beat entry still plays for one beat.
   function automatic logic [LEN_BITS-1:0] sanitize(input logic [WORD-1:0] w);
      sanitize = (w[LEN_BITS-1:0] == '0) ? LEN_BITS'(1) : w[LEN_BITS-1:0];
   endfunction

   assign idx_inc    = {1'b0, idx_q} + (ADDR_BITS+1)'(1);
   assign song_len_c = (song_len > (ADDR_BITS+1)'(DEPTH)) ?
                       (ADDR_BITS+1)'(DEPTH) : song_len;

   // Song RAM: writes only land while idle so playback data is stable.
   always_ff @(posedge game_clock) begin
      if (wr_en && state_q == IDLE)
         mem[wr_addr] <= wr_data;
   end

   // Look-ahead pitch: following entry, entry 0 on a loop, else nothing.
   always_comb begin
      next_note = '0;
      if (state_q == PLAY) begin
         if (idx_inc < len_q)
            next_note = decode(mem[idx_inc[ADDR_BITS-1:0]]);
         else if (loop_en)
            next_note = decode(mem[0]);
      end
   end

   // Next-state and next-output computation; start beats a same-cycle tick.
   always_comb begin
      state_d   = state_q;
      idx_d     = idx_q;
      len_d     = len_q;
      beats_d   = beats_q;
      hold_d    = hold_q;
      curr_d    = curr_q;
      ns_d      = 1'b0;
      done_d    = 1'b0;
      load      = 1'b0;
      clear     = 1'b0;
      load_word = '0;
      unique case (state_q)
         IDLE: begin
            if (start && song_len != '0) begin
               state_d = PLAY;
               idx_d   = '0;
               len_d   = song_len_c;
               load    = 1'b1;
            end
         end
         PLAY: begin
            if (start && song_len != '0) begin
               idx_d = '0;
               len_d = song_len_c;
               load  = 1'b1;
            end else if (start) begin
               state_d = IDLE;
               clear   = 1'b1;
            end else if (beat_tick && beats_q > LEN_BITS'(1)) begin
               beats_d = beats_q - LEN_BITS'(1);
            end else if (beat_tick && idx_inc < len_q) begin
               idx_d = idx_inc[ADDR_BITS-1:0];
               load  = 1'b1;
            end else if (beat_tick && loop_en) begin
               idx_d = '0;
               load  = 1'b1;
            end else if (beat_tick) begin
               state_d = IDLE;
               done_d  = 1'b1;
               clear   = 1'b1;
            end
         end
         default: state_d = IDLE;
      endcase
      load_word = mem[idx_d];
      if (load) begin
         ns_d    = 1'b1;
         curr_d  = decode(load_word);
         hold_d  = sanitize(load_word);
         beats_d = sanitize(load_word);
      end
      if (clear) begin
         idx_d   = '0;
         curr_d  = '0;
         hold_d  = '0;
         beats_d = '0;
      end
   end

   // State and registered outputs.
   always_ff @(posedge game_clock or posedge reset) begin
      if (reset) begin
         state_q <= IDLE;
         idx_q   <= '0;
         len_q   <= '0;
         beats_q <= '0;
         hold_q  <= '0;
         curr_q  <= '0;
         ns_q    <= 1'b0;
         done_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         idx_q   <= idx_d;
         len_q   <= len_d;
         beats_q <= beats_d;
         hold_q  <= hold_d;
         curr_q  <= curr_d;
         ns_q    <= ns_d;
         done_q  <= done_d;
      end
   end

   assign curr_note   = curr_q;
   assign hold_length = hold_q;
   assign beats_left  = beats_q;
   assign note_start  = ns_q;
   assign done        = done_q;
   assign busy        = (state_q == PLAY);

endmodule

// File: doc/song_sequencer.md
Name: song_sequencer

Overview:
- Parametrised note sequencer; successor to the fixed-map song engine.
- Song RAM is loadable at run time. Playback is driven by a per-beat tick instead of absolute frame comparison.
- Presents the current note, the next note, hold length and remaining beats to the tile renderer and tone generator.
- Adds start/restart, optional looping, zero-length sanitising and a done pulse.

Parameters:
NOTE_BITS, 4, width of note identifier field
LEN_BITS, 4, width of beat-length field
ADDR_BITS, 6, song RAM address width; depth = 2**ADDR_BITS
LANES, 12, one-hot output width (one bit per playable pitch)
REST_CODE, 15, note identifier meaning silence

Ports:
game_clock  in  1  system clock
reset  in  1  asynchronous, active-high reset
wr_en  in  1  song RAM write strobe, honoured only in IDLE
wr_addr  in  ADDR_BITS  write address
wr_data  in  NOTE_BITS+LEN_BITS  {note, length}, note in MSBs
song_len  in  ADDR_BITS+1  number of valid entries, sampled on start
start  in  1  begin or restart playback at entry 0
loop_en  in  1  wrap to entry 0 after last entry (sampled live)
beat_tick  in  1  one-cycle pulse per beat
curr_note  out  LANES  one-hot current pitch; 0 for rest or idle
next_note  out  LANES  one-hot pitch of following entry; 0 if none
hold_length  out  LEN_BITS  sanitised length of current entry
beats_left  out  LEN_BITS  beats remaining on current entry, including the current beat
note_start  out  1  one-cycle pulse when a new entry becomes current
busy  out  1  high in PLAY
done  out  1  one-cycle pulse on non-looping song end

Behaviour:
- Reset (async, active-high): state IDLE, index 0, latched length 0. All outputs are 0. RAM contents are not cleared.
- RAM has a synchronous write and a combinational read. wr_en in PLAY is ignored; the RAM is unchanged.
- Sanitising: a length field of 0 is treated as 1 everywhere, including hold_length and beats_left.
- One-hot decode: a note equal to REST_CODE, or any note >= LANES, decodes to all zeros.
- FSM states: IDLE and PLAY.
- IDLE:
  - start with song_len != 0: latch song_len. Next cycle: PLAY, index 0, beats_left = len[0], note_start = 1.
  - start with song_len == 0: no effect, stays IDLE.
- PLAY, beat_tick with beats_left > 1: beats_left decrements the next cycle.
- PLAY, beat_tick with beats_left == 1 and index+1 < latched length: next cycle index+1, beats_left = its length, note_start = 1.
- PLAY, beat_tick with beats_left == 1 and index+1 == latched length:
  - loop_en = 1: index 0, note_start = 1.
  - loop_en = 0: next cycle IDLE, done = 1, all note outputs 0.
- curr_note and hold_length are registered from the current index; they update in the same cycle as note_start.
- next_note depends on the position of the current entry:
  - not last entry: decode of entry index+1;
  - last entry with loop_en = 1: decode of entry 0;
  - last entry with loop_en = 0: 0.
- start in PLAY: restart at index 0 with a fresh song_len sample and a note_start pulse.
- start and beat_tick in the same cycle: start wins and the tick is discarded.
- beat_tick in IDLE: ignored.
- Index and length arithmetic are unsigned. The index never exceeds latched length minus 1. A song_len greater than the depth is clamped to 2**ADDR_BITS.
- Latency: start or final tick to new outputs is 1 cycle.

Test Plan:
1. Load {0,1},{7,2},{15,1}; song_len=3; pulse start.
   - Next cycle: curr_note=0x001, next_note=0x080, hold_length=1, beats_left=1, note_start=1, busy=1.
2. Continue scenario 1 with ticks.
   - Tick 1: curr_note=0x080, beats_left=2.
   - Tick 2: beats_left=1, no note_start.
   - Tick 3: curr_note=0, next_note=0.
   - Tick 4: done=1, busy=0 the next cycle.
3. Same song with loop_en=1.
   - While on entry 2, next_note=0x001.
   - Tick 4: index 0, curr_note=0x001, note_start=1, no done.
4. Entry {5,0} and entry {13,1}.
   - {5,0}: hold_length=1, advances after one tick.
   - {13,1}: curr_note=0.
5. During PLAY, assert wr_en to address 1; then assert start and beat_tick together.
   - Write is ignored: readback after end still shows the old data.
   - Playback restarts at index 0 with a single note_start pulse and no decrement.
6. Assert reset mid-note; release it, then pulse start with song_len=0.
   - During reset all outputs are 0 immediately; after release state is IDLE.
   - start with song_len=0: stays IDLE, busy=0, no note_start.
